// File: rtl/control_unit_types_pkg.sv
// Control-unit enumerations: writeback source select and MM/WB access FSM state.
// Latency: n/a (types only).
// Backpressure: n/a.
package control_unit_types_pkg;
  // Encoding 3 is unused by the decoder and falls back to the ALU result.
  typedef enum logic [1:0] {
    ALU = 2'd0,
    MEM = 2'd1,
    NPC = 2'd2
  } memtoreg_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    CAPTURED = 2'd2
  } mmwb_state_t;
endpackage

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word and register-file index.
// Latency: n/a (types only).
// Backpressure: n/a.
package cpu_types_pkg;
  localparam int WORD_W = 32;
  localparam int REG_W  = 5;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  regbits_t;
endpackage

// File: rtl/mmwbpipe_if.sv
// Bundles the MM-side exmm fields (modport mm) and the WB-side results (modport wb).
// Latency: n/a (wiring only).
// Backpressure: n/a; stall is carried as mmstall in the wb group.
interface mmwbpipe_if;
  import cpu_types_pkg::*;

  // Kept as a raw 2-bit field so the undecoded value 3 survives intact.
  logic [1:0] MemtoReg;
  logic       RegWEN;
  logic       dRENi;
  logic       dWENi;
  logic       halt;
  regbits_t   rd;
  word_t      ALUOut;
  word_t      npc;

  regbits_t   wsel;
  logic       WEN;
  word_t      wdat;
  logic       halt_o;
  logic       mmstall;

  modport mm (input MemtoReg, RegWEN, dRENi, dWENi, halt, rd, ALUOut, npc);
  modport wb (output wsel, WEN, wdat, halt_o, mmstall);
endinterface

// File: rtl/wbsel_mux.sv
// Writeback data select: ALU result, next PC, or load data (live dload on a hit, else ldbuf).
// Latency: combinational.
// Backpressure: none.
// Ports: memtoreg (select), alu_out, npc, dhit, dload, ldbuf in; wdat out.
module wbsel_mux (
  input  logic [1:0]  memtoreg,
  input  logic [31:0] alu_out,
  input  logic [31:0] npc,
  input  logic        dhit,
  input  logic [31:0] dload,
  input  logic [31:0] ldbuf,
  output logic [31:0] wdat
);
  import control_unit_types_pkg::*;

  always_comb begin
    wdat = alu_out;
    case (memtoreg)
      MEM:     wdat = dhit ? dload : ldbuf;
      NPC:     wdat = npc;
      default: wdat = alu_out;  // ALU, and the unused encoding 3
    endcase
  end
endmodule

// File: rtl/mmwbpipe.sv
// MM/WB pipeline register with data-cache access FSM, load buffer and sticky halt.
// Latency: 1 cycle from advance (ihit & ~mmstall) to wsel/WEN/wdat/halt_o.
// Backpressure: mmstall raised while a memory access is outstanding; WEN drops to 0 on any non-advance cycle.
// Ports: CLK, nRST (async active-low); ihit, dhit, dload; exmm fields MemtoReg, RegWEN, dRENi,
//   dWENi, halt, rd, ALUOut, npc; outputs wsel, WEN, wdat, halt_o, mmstall.
// Option MMWB_FWD_EN: adds fwd_rd, fwd_val, fwd_data (next-cycle writeback, combinational).
module mmwbpipe (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic [31:0] dload,
  input  logic [1:0]  MemtoReg,
  input  logic        RegWEN,
  input  logic        dRENi,
  input  logic        dWENi,
  input  logic        halt,
  input  logic [4:0]  rd,
  input  logic [31:0] ALUOut,
  input  logic [31:0] npc,
  output logic [4:0]  wsel,
  output logic        WEN,
  output logic [31:0] wdat,
  output logic        halt_o,
  output logic        mmstall
`ifdef MMWB_FWD_EN
  ,
  output logic [4:0]  fwd_rd,
  output logic        fwd_val,
  output logic [31:0] fwd_data
`endif
);
  import cpu_types_pkg::*;
  import control_unit_types_pkg::*;

  mmwbpipe_if bus ();

  assign bus.MemtoReg = MemtoReg;
  assign bus.RegWEN   = RegWEN;
  assign bus.dRENi    = dRENi;
  assign bus.dWENi    = dWENi;
  assign bus.halt     = halt;
  assign bus.rd       = rd;
  assign bus.ALUOut   = ALUOut;
  assign bus.npc      = npc;

  mmwb_state_t state;
  mmwb_state_t state_nxt;
  word_t       ldbuf;
  word_t       wb_data;
  regbits_t    wsel_q;
  logic        wen_q;
  word_t       wdat_q;
  logic        halt_q;
  logic        req;
  logic        stall;
  logic        advance;

  assign req     = bus.dRENi | bus.dWENi;
  assign advance = ihit & ~stall;

  // FSM state register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next state. A hit that coincides with ihit retires straight
  // through; a hit without ihit parks the result in CAPTURED.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req && !dhit)              state_nxt = ACCESS;
        else if (req && dhit && !ihit) state_nxt = CAPTURED;
      end
      ACCESS: begin
        if (dhit) state_nxt = ihit ? IDLE : CAPTURED;
      end
      CAPTURED: begin
        if (ihit) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM output: once data is captured the stage no longer needs to stall.
  always_comb begin
    stall = req & ~dhit & (state != CAPTURED);
  end

  // Load buffer keeps the last returned load word for a later advance.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)              ldbuf <= '0;
    else if (dhit && dRENi) ldbuf <= dload;
  end

  wbsel_mux u_wbsel (
    .memtoreg (bus.MemtoReg),
    .alu_out  (bus.ALUOut),
    .npc      (bus.npc),
    .dhit     (dhit),
    .dload    (dload),
    .ldbuf    (ldbuf),
    .wdat     (wb_data)
  );

  // Writeback register. WEN is a one-cycle pulse per advanced instruction,
  // so bubbles and idle cycles never repeat a register-file write.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wsel_q <= '0;
      wen_q  <= 1'b0;
      wdat_q <= '0;
      halt_q <= 1'b0;
    end else if (advance) begin
      wsel_q <= bus.rd;
      wen_q  <= bus.RegWEN;
      wdat_q <= wb_data;
      if (bus.halt) halt_q <= 1'b1;
    end else begin
      wen_q  <= 1'b0;
    end
  end

  assign bus.wsel    = wsel_q;
  assign bus.WEN     = wen_q;
  assign bus.wdat    = wdat_q;
  assign bus.halt_o  = halt_q;
  assign bus.mmstall = stall;

  assign wsel    = bus.wsel;
  assign WEN     = bus.WEN;
  assign wdat    = bus.wdat;
  assign halt_o  = bus.halt_o;
  assign mmstall = bus.mmstall;

`ifdef MMWB_FWD_EN
  // Next-cycle writeback view, so the forwarding unit sees the result one cycle early.
  assign fwd_rd   = advance ? bus.rd : wsel_q;
  assign fwd_val  = advance & bus.RegWEN;
  assign fwd_data = advance ? wb_data : wdat_q;
`endif
endmodule

// File: tb/tb_mmwbpipe.sv
// Self-checking bench for mmwbpipe: directed scenarios plus randomized instruction stream
// checked against an instruction-level reference model.
// Optional checks for the forwarding outputs when MMWB_FWD_EN is defined.
module tb_mmwbpipe;
  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        ihit, dhit;
  logic [31:0] dload;
  logic [1:0]  MemtoReg;
  logic        RegWEN, dRENi, dWENi, halt;
  logic [4:0]  rd;
  logic [31:0] ALUOut, npc;
  logic [4:0]  wsel;
  logic        WEN;
  logic [31:0] wdat;
  logic        halt_o, mmstall;
`ifdef MMWB_FWD_EN
  logic [4:0]  fwd_rd;
  logic        fwd_val;
  logic [31:0] fwd_data;
`endif

  localparam logic [1:0] T_ALU = 2'd0, T_MEM = 2'd1, T_NPC = 2'd2;
  localparam int ST_IDLE = 0, ST_ACCESS = 1, ST_CAPT = 2;

  always #5 CLK = ~CLK;

  mmwbpipe dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dload(dload),
    .MemtoReg(MemtoReg), .RegWEN(RegWEN), .dRENi(dRENi), .dWENi(dWENi),
    .halt(halt), .rd(rd), .ALUOut(ALUOut), .npc(npc),
    .wsel(wsel), .WEN(WEN), .wdat(wdat), .halt_o(halt_o), .mmstall(mmstall)
`ifdef MMWB_FWD_EN
    , .fwd_rd(fwd_rd), .fwd_val(fwd_val), .fwd_data(fwd_data)
`endif
  );

  // Reference model: architectural writeback view plus whether the current
  // memory instruction has already had its data returned (got) or is waiting.
  logic [4:0]  m_wsel;
  logic        m_wen, m_halt, m_got, m_wait;
  logic [31:0] m_wdat, m_ldbuf;
  int n_vec = 0;
  int n_bad = 0;
  logic adv;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] wb_val(input logic [1:0] mt, input logic [31:0] alu,
                                         input logic [31:0] pc, input logic [31:0] ld);
    if (mt == T_MEM) return ld;
    if (mt == T_NPC) return pc;
    return alu;
  endfunction

  task automatic model_reset();
    m_wsel = '0; m_wen = 1'b0; m_wdat = '0; m_ldbuf = '0;
    m_halt = 1'b0; m_got = 1'b0; m_wait = 1'b0;
  endtask

  task automatic set_instr(input logic [1:0] mt, input logic wen, input logic ren, input logic wr,
                           input logic hlt, input logic [4:0] r, input logic [31:0] alu,
                           input logic [31:0] pc);
    MemtoReg = mt; RegWEN = wen; dRENi = ren; dWENi = wr; halt = hlt;
    rd = r; ALUOut = alu; npc = pc;
  endtask

  task automatic set_cyc(input logic ih, input logic dh, input logic [31:0] dl);
    ihit = ih; dhit = dh; dload = dl;
  endtask

  // Called at posedge+1 with this cycle's inputs already applied.
  task automatic step(output logic advanced);
    logic        stall;
    logic [31:0] ld;
    int          exp_state;
    #1;
    stall    = (dRENi | dWENi) & ~dhit & ~m_got;
    advanced = ihit & ~stall;
    ld       = dhit ? dload : m_ldbuf;
    chk("mmstall", 32'(mmstall), 32'(stall));
`ifdef MMWB_FWD_EN
    chk("fwd_val", 32'(fwd_val), 32'(advanced & RegWEN));
    chk("fwd_rd", 32'(fwd_rd), 32'(advanced ? rd : m_wsel));
    chk("fwd_data", fwd_data, advanced ? wb_val(MemtoReg, ALUOut, npc, ld) : m_wdat);
`endif
    @(posedge CLK);
    if (advanced) begin
      m_wsel = rd; m_wen = RegWEN; m_wdat = wb_val(MemtoReg, ALUOut, npc, ld);
      if (halt) m_halt = 1'b1;
      m_got = 1'b0; m_wait = 1'b0;
    end else begin
      m_wen = 1'b0;
      if (dRENi | dWENi) begin
        if (dhit) begin m_got = 1'b1; m_wait = 1'b0; end
        else if (!m_got) m_wait = 1'b1;
      end
    end
    if (dhit && dRENi) m_ldbuf = dload;
    #1;
    exp_state = m_got ? ST_CAPT : (m_wait ? ST_ACCESS : ST_IDLE);
    chk("wsel", 32'(wsel), 32'(m_wsel));
    chk("WEN", 32'(WEN), 32'(m_wen));
    chk("wdat", wdat, m_wdat);
    chk("halt_o", 32'(halt_o), 32'(m_halt));
    chk("state", 32'(dut.state), 32'(exp_state));
    chk("ldbuf", dut.ldbuf, m_ldbuf);
  endtask

  task automatic rand_instr();
    logic [1:0] mt;
    logic       wen, ren, wr;
    ren = 1'b0; wr = 1'b0;
    case ($urandom_range(0, 4))
      0:       begin mt = T_ALU; wen = 1'($urandom_range(0, 1)); end
      1:       begin mt = T_MEM; wen = 1'b1; ren = 1'b1; end
      2:       begin mt = T_ALU; wen = 1'b0; wr = 1'b1; end
      3:       begin mt = T_NPC; wen = 1'b1; end
      default: begin mt = 2'd3;  wen = 1'b1; end
    endcase
    set_instr(mt, wen, ren, wr, 1'b0, 5'($urandom), 32'($urandom), 32'($urandom));
  endtask

  initial begin
    model_reset();
    set_instr(T_ALU, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    set_cyc(1'b0, 1'b0, 32'd0);
    #2;
    chk("rst_wsel", 32'(wsel), 32'd0);
    chk("rst_WEN", 32'(WEN), 32'd0);
    chk("rst_wdat", wdat, 32'd0);
    chk("rst_halt", 32'(halt_o), 32'd0);
    chk("rst_stall", 32'(mmstall), 32'd0);
    chk("rst_state", 32'(dut.state), 32'(ST_IDLE));
    @(negedge CLK) nRST = 1'b1;
    @(posedge CLK); #1;

    // ALU op then an idle cycle
    set_instr(T_ALU, 1'b1, 1'b0, 1'b0, 1'b0, 5'd8, 32'h0000_0010, 32'd0);
    set_cyc(1'b1, 1'b0, 32'd0);
    step(adv);
    chk("alu_wsel", 32'(wsel), 32'd8);
    chk("alu_WEN", 32'(WEN), 32'd1);
    chk("alu_wdat", wdat, 32'h10);
    set_cyc(1'b0, 1'b0, 32'd0);
    step(adv);
    chk("alu_idle_WEN", 32'(WEN), 32'd0);

    // Load with dhit at cycle 2, ihit at cycle 4
    set_instr(T_MEM, 1'b1, 1'b1, 1'b0, 1'b0, 5'd4, 32'h5555, 32'h6666);
    set_cyc(1'b0, 1'b0, 32'h0BAD_0001);
    #1 chk("ld_c1_stall", 32'(mmstall), 32'd1);
    step(adv);
    set_cyc(1'b0, 1'b1, 32'hDEAD_BEEF);
    step(adv);
    chk("ld_c2_state", 32'(dut.state), 32'(ST_CAPT));
    set_cyc(1'b0, 1'b0, 32'h0BAD_0003);
    step(adv);
    chk("ld_c3_state", 32'(dut.state), 32'(ST_CAPT));
    set_cyc(1'b1, 1'b0, 32'h0BAD_0004);
    #1 chk("ld_c4_stall", 32'(mmstall), 32'd0);
    step(adv);
    chk("ld_wdat", wdat, 32'hDEAD_BEEF);
    chk("ld_state", 32'(dut.state), 32'(ST_IDLE));

    // Load with dhit and ihit together
    set_instr(T_MEM, 1'b1, 1'b1, 1'b0, 1'b0, 5'd5, 32'h1, 32'h2);
    set_cyc(1'b1, 1'b1, 32'hCAFE_F00D);
    step(adv);
    chk("ld2_wdat", wdat, 32'hCAFE_F00D);
    chk("ld2_state", 32'(dut.state), 32'(ST_IDLE));

    // Bubble: ihit while stalled
    set_instr(T_MEM, 1'b1, 1'b1, 1'b0, 1'b0, 5'd6, 32'h1, 32'h2);
    set_cyc(1'b1, 1'b0, 32'h0);
    step(adv);
    chk("bub_WEN", 32'(WEN), 32'd0);
    chk("bub_wdat", wdat, 32'hCAFE_F00D);
    set_cyc(1'b1, 1'b1, 32'h1234_5678);
    step(adv);
    chk("bub_done_wdat", wdat, 32'h1234_5678);

    // Store: ldbuf untouched, no register write
    set_instr(T_ALU, 1'b0, 1'b0, 1'b1, 1'b0, 5'd7, 32'h100, 32'h0);
    set_cyc(1'b1, 1'b0, 32'h0);
    step(adv);
    set_cyc(1'b1, 1'b1, 32'hFFFF_0000);
    step(adv);
    chk("st_WEN", 32'(WEN), 32'd0);
    chk("st_ldbuf", dut.ldbuf, 32'h1234_5678);

    // MemtoReg=3 falls back to ALUOut
    set_instr(2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 32'h0000_ABCD, 32'h99);
    set_cyc(1'b1, 1'b0, 32'h0);
    step(adv);
    chk("mt3_wdat", wdat, 32'h0000_ABCD);

    // jal: next PC writeback (and same-cycle forwarding when enabled)
    set_instr(T_NPC, 1'b1, 1'b0, 1'b0, 1'b0, 5'd31, 32'h0, 32'h0000_0044);
    set_cyc(1'b1, 1'b0, 32'h0);
`ifdef MMWB_FWD_EN
    #1;
    chk("jal_fwd_rd", 32'(fwd_rd), 32'd31);
    chk("jal_fwd_val", 32'(fwd_val), 32'd1);
    chk("jal_fwd_data", fwd_data, 32'h44);
`endif
    step(adv);
    chk("jal_wdat", wdat, 32'h44);

    // Randomized instruction stream
    adv = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if (adv) rand_instr();
      ihit  = ($urandom_range(0, 9) < 6);
      dhit  = (dRENi | dWENi) && ($urandom_range(0, 9) < 4);
      dload = $urandom;
      step(adv);
    end

    // Halt, then 10 idle cycles
    set_instr(T_ALU, 1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 32'h77, 32'h0);
    set_cyc(1'b1, 1'b0, 32'h0);
    step(adv);
    chk("halt_set", 32'(halt_o), 32'd1);
    set_instr(T_ALU, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    set_cyc(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 10; i++) step(adv);
    chk("halt_held", 32'(halt_o), 32'd1);

    // Asynchronous reset mid-ACCESS
    set_instr(T_MEM, 1'b1, 1'b1, 1'b0, 1'b0, 5'd12, 32'h0, 32'h0);
    set_cyc(1'b0, 1'b0, 32'h1111);
    step(adv);
    chk("pre_rst_state", 32'(dut.state), 32'(ST_ACCESS));
    #2 nRST = 1'b0;
    #1;
    chk("arst_wsel", 32'(wsel), 32'd0);
    chk("arst_WEN", 32'(WEN), 32'd0);
    chk("arst_wdat", wdat, 32'd0);
    chk("arst_halt", 32'(halt_o), 32'd0);
    chk("arst_state", 32'(dut.state), 32'(ST_IDLE));
    chk("arst_ldbuf", dut.ldbuf, 32'd0);
    chk("arst_stall_req", 32'(mmstall), 32'd1);
    set_instr(T_ALU, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    #1 chk("arst_stall_noreq", 32'(mmstall), 32'd0);
    model_reset();
    @(negedge CLK) nRST = 1'b1;
    @(posedge CLK); #1;

    set_instr(T_ALU, 1'b1, 1'b0, 1'b0, 1'b0, 5'd2, 32'h0000_0BEE, 32'h0);
    set_cyc(1'b1, 1'b0, 32'h0);
    step(adv);
    chk("post_rst_wdat", wdat, 32'h0BEE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/mmwbpipe.md
MMWBPIPE -- requirements
Module: mmwbpipe

Interface
REQ-001 SHALL have ports: CLK in 1, rising-edge clock; nRST in 1, asynchronous active-low reset.
REQ-002 SHALL have inputs: ihit 1, instruction fetch hit / pipeline advance; dhit 1, data cache hit; dload 32 (word_t), data returned by the data cache.
REQ-003 SHALL have inputs from the MM side of the exmm register: MemtoReg 2 (memtoreg_t: ALU=0, MEM=1, NPC=2); RegWEN 1; dRENi 1; dWENi 1; halt 1; rd 5 (regbits_t); ALUOut 32; npc 32.
REQ-004 SHALL have outputs: wsel 5, writeback register; WEN 1, register-file write enable; wdat 32, writeback data; halt_o 1, sticky halt to the datapath; mmstall 1, memory-stage stall request.

Function
REQ-005 SHALL keep FSM state mmwb_state_t: IDLE, ACCESS, CAPTURED.
REQ-006 IDLE -> ACCESS when (dRENi|dWENi)=1 and dhit=0. IDLE -> CAPTURED when the request is present and dhit=1 and ihit=0.
REQ-007 ACCESS -> CAPTURED on dhit=1 with ihit=0. ACCESS -> IDLE on dhit=1 with ihit=1.
REQ-008 CAPTURED -> IDLE on ihit=1. All other combinations hold state.
REQ-009 On dhit while dRENi=1, SHALL latch dload into a load buffer ldbuf (32); ldbuf holds until the next dhit.
REQ-010 mmstall SHALL equal (dRENi|dWENi) & ~dhit & (state!=CAPTURED), combinationally.
REQ-011 Advance SHALL occur on a cycle with ihit=1 and mmstall=0; wsel, WEN, wdat, halt_o update at the next rising edge (1-cycle latency).
REQ-012 On advance: wsel<=rd; WEN<=RegWEN; wdat<=ALUOut if MemtoReg=ALU, npc if NPC, load data if MEM.
REQ-013 Load data for MEM SHALL be dload when dhit=1 this cycle, otherwise ldbuf (state CAPTURED).
REQ-014 On ihit=1 with mmstall=1 (bubble), SHALL load WEN<=0 and leave wsel, wdat unchanged, so no register write is repeated.
REQ-015 With ihit=0 and no advance, WEN SHALL clear to 0 after one cycle, so each instruction writes exactly once.
REQ-016 halt_o SHALL set on advance with halt=1 and SHALL stay 1 until reset.
REQ-017 A store (dWENi=1) SHALL follow the same FSM. ldbuf is not written and WEN follows RegWEN (0 for stores).
REQ-018 MemtoReg=3 SHALL produce wdat=ALUOut.

Reset
REQ-019 On nRST=0, at any time, SHALL immediately force state=IDLE, wsel=0, WEN=0, wdat=0, ldbuf=0, halt_o=0. A pending access is discarded.
REQ-020 mmstall SHALL be 0 during reset whenever dRENi=dWENi=0.

Configuration
REQ-021 With MMWB_FWD_EN defined, SHALL add outputs fwd_rd 5, fwd_val 1, fwd_data 32, combinationally equal to the next-cycle wsel, advance&RegWEN, and the next-cycle wdat, for the forwarding unit. fwd_val SHALL be 0 during mmstall.
REQ-022 Without MMWB_FWD_EN, these ports and their logic SHALL be absent. All other behaviour is identical.

Structure
REQ-023 memtoreg_t and mmwb_state_t SHALL live in control_unit_types_pkg. word_t and regbits_t SHALL come from cpu_types_pkg.
REQ-024 The writeback data select (REQ-012/013/018) SHALL be a combinational sub-module wbsel_mux, shared with the forwarding path.
REQ-025 Port groups SHALL be bundled in mmwbpipe_if with modports mm and wb.

Verification
REQ-026 ALU op: MemtoReg=ALU, ALUOut=0x0000_0010, rd=8, RegWEN=1, ihit=1 -> next cycle wsel=8, WEN=1, wdat=0x10; following idle cycle WEN=0.
REQ-027 Load, dhit before ihit: dRENi=1, dhit at cycle 2 with dload=0xDEAD_BEEF, ihit at cycle 4 -> mmstall high cycle 1 only, state CAPTURED cycles 3-4, wdat=0xDEADBEEF after cycle 4.
REQ-028 Load, dhit and ihit in the same cycle -> state stays IDLE, wdat=dload of that cycle, no CAPTURED visit.
REQ-029 Bubble: ihit=1 while mmstall=1 -> WEN=0 next cycle, wdat unchanged.
REQ-030 Halt and reset: advance with halt=1 -> halt_o=1 and held through 10 idle cycles. nRST pulsed mid-ACCESS -> all outputs 0 and state IDLE asynchronously.
REQ-031 With MMWB_FWD_EN: jal with MemtoReg=NPC, npc=0x0000_0044, rd=31 -> same cycle fwd_rd=31, fwd_val=1, fwd_data=0x44.
